// File: rtl/cordic_bus_bridge_if.sv
// BusInterface: signal bundle between the host bus bridge and the CORDIC core.
//   bus  modport : bridge side; drives operands, control image, clk and rst,
//                  samples results, controller write-back and interrupt.
//   core modport : CORDIC side, the mirror image of the bus modport.
// Parameter p_WIDTH sets the width of every operand/result/control bus.
interface BusInterface #(
  parameter int p_WIDTH = 32
);
  logic               clk;
  logic               rst;
  logic [p_WIDTH-1:0] xInput;
  logic [p_WIDTH-1:0] yInput;
  logic [p_WIDTH-1:0] zInput;
  logic [p_WIDTH-1:0] controlRegisterInput;
  logic [p_WIDTH-1:0] xResult;
  logic [p_WIDTH-1:0] yResult;
  logic [p_WIDTH-1:0] zResult;
  logic [p_WIDTH-1:0] controlRegisterOutput;
  logic               controlRegisterWriteEnable;
  logic               interrupt;

  modport bus (
    output xInput, yInput, zInput, controlRegisterInput, clk, rst,
    input  xResult, yResult, zResult, controlRegisterOutput,
           controlRegisterWriteEnable, interrupt
  );

  modport core (
    input  xInput, yInput, zInput, controlRegisterInput, clk, rst,
    output xResult, yResult, zResult, controlRegisterOutput,
           controlRegisterWriteEnable, interrupt
  );
endinterface

// File: rtl/cordic_bus_bridge.sv
// cordic_bus_bridge: valid/ready host bus to CORDIC register bridge.
//   Word map: 0 X, 1 Y, 2 Z, 3 CTRL, 4 IRQSTAT, 5-7 unmapped (error response).
// Ports:
//   clk, rst            clock and asynchronous active-low reset (forwarded to the core)
//   req_valid/req_ready request handshake; req_write, req_addr[2:0], req_wdata
//   resp_valid/resp_ready response handshake; resp_rdata, resp_err
//   irq                 level interrupt, mirrors the pending flag
//   cordic              BusInterface.bus towards the CORDIC core
// p_WIDTH must exceed 16: the CTRL image splits at bit 16 between host-owned
// low bits and controller-owned high bits.
module cordic_bus_bridge #(
  parameter int p_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [2:0]         req_addr,
  input  logic [p_WIDTH-1:0] req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [p_WIDTH-1:0] resp_rdata,
  output logic               resp_err,
  output logic               irq,
  BusInterface.bus           cordic
);

  localparam logic [2:0] ADDR_X    = 3'd0;
  localparam logic [2:0] ADDR_Y    = 3'd1;
  localparam logic [2:0] ADDR_Z    = 3'd2;
  localparam logic [2:0] ADDR_CTRL = 3'd3;
  localparam logic [2:0] ADDR_IRQ  = 3'd4;

  typedef enum logic {IDLE, RESP} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               addr_err;
  logic               wr_x, wr_y, wr_z, wr_ctrl, irq_clr;
  logic [p_WIDTH-1:0] rd_data;
  logic [p_WIDTH-1:0] x_hold, y_hold, z_hold;
  logic [p_WIDTH-1:0] ctrl_img;
  logic [1:0]         ctrl_pulse;
  logic               int_d;
  logic               int_rise;
  logic               irq_pending;
  logic               unused_ctrl_bits;

  // Clock and reset pass straight through to the core.
  assign cordic.clk = clk;
  assign cordic.rst = rst;

  // Acceptance depends only on the registered state, so there is no
  // combinational path from req_valid back into req_ready.
  assign accept   = req_valid && (state == IDLE);
  assign addr_err = (req_addr > ADDR_IRQ);
  assign wr_x     = accept && req_write && (req_addr == ADDR_X);
  assign wr_y     = accept && req_write && (req_addr == ADDR_Y);
  assign wr_z     = accept && req_write && (req_addr == ADDR_Z);
  assign wr_ctrl  = accept && req_write && (req_addr == ADDR_CTRL);
  assign irq_clr  = accept && req_write && (req_addr == ADDR_IRQ) && req_wdata[0];
  assign int_rise = cordic.interrupt && !int_d;

  // Start/Stop only ever live in the pulse register; the image keeps them at 0.
  assign cordic.controlRegisterInput = ctrl_img | {{(p_WIDTH-2){1'b0}}, ctrl_pulse};
  assign cordic.xInput = x_hold;
  assign cordic.yInput = y_hold;
  assign cordic.zInput = z_hold;
  assign irq           = irq_pending;

  // The controller never writes the pulse bits back into the image.
  assign unused_ctrl_bits = ^cordic.controlRegisterOutput[1:0];

  // Transaction state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and handshake outputs: one transaction outstanding at a time.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read mux; unmapped addresses fall through to zero.
  always_comb begin
    rd_data = '0;
    case (req_addr)
      ADDR_X:    rd_data = cordic.xResult;
      ADDR_Y:    rd_data = cordic.yResult;
      ADDR_Z:    rd_data = cordic.zResult;
      ADDR_CTRL: rd_data = ctrl_img;
      ADDR_IRQ:  rd_data = {{(p_WIDTH-1){1'b0}}, irq_pending};
      default:   rd_data = '0;
    endcase
  end

  // Response payload is captured at acceptance and held through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_rdata <= req_write ? '0 : rd_data;
      resp_err   <= addr_err;
    end
  end

  // Operand hold registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_hold <= '0;
      y_hold <= '0;
      z_hold <= '0;
    end else begin
      if (wr_x) x_hold <= req_wdata;
      if (wr_y) y_hold <= req_wdata;
      if (wr_z) z_hold <= req_wdata;
    end
  end

  // CTRL image: the controller owns the upper half, the host has priority
  // on bits [15:2] when both write in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_img <= '0;
    end else begin
      if (cordic.controlRegisterWriteEnable)
        ctrl_img[p_WIDTH-1:16] <= cordic.controlRegisterOutput[p_WIDTH-1:16];
      if (wr_ctrl)
        ctrl_img[15:2] <= req_wdata[15:2];
      else if (cordic.controlRegisterWriteEnable)
        ctrl_img[15:2] <= cordic.controlRegisterOutput[15:2];
    end
  end

  // Start/Stop pulses last exactly the cycle after the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ctrl_pulse <= 2'b00;
    else      ctrl_pulse <= wr_ctrl ? req_wdata[1:0] : 2'b00;
  end

  // Interrupt edge detect; a new edge beats a simultaneous host clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_d       <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      int_d <= cordic.interrupt;
      if (int_rise)     irq_pending <= 1'b1;
      else if (irq_clr) irq_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_bus_bridge.sv
// Self-checking bench for cordic_bus_bridge: directed scenarios followed by
// randomized transactions, all compared against a register-level model.
module tb_cordic_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        irq;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model state: what the register map should hold.
  logic [31:0] mX, mY, mZ, mImg;
  logic        mPend;
  logic [31:0] lastRdata;

  BusInterface #(.p_WIDTH(32)) cordicIf ();

  cordic_bus_bridge #(.p_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .irq        (irq),
    .cordic     (cordicIf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mX = '0; mY = '0; mZ = '0; mImg = '0; mPend = 1'b0;
  endtask

  task automatic checkRegs();
    checkOutput("x_input", cordicIf.xInput, mX);
    checkOutput("y_input", cordicIf.yInput, mY);
    checkOutput("z_input", cordicIf.zInput, mZ);
    checkOutput("irq", {31'b0, irq}, {31'b0, mPend});
  endtask

  // One complete host transaction. intPulse/ctrlWe put a core event in the
  // very cycle the request is accepted; hold is the number of cycles the
  // response is left waiting before resp_ready is raised.
  task automatic applyStimulus(input bit wr, input logic [2:0] addr, input logic [31:0] wdata,
                               input int hold, input bit intPulse, input bit ctrlWe,
                               input logic [31:0] ctrlOut);
    logic [31:0] expRd;
    logic        expErr;
    logic [1:0]  pulse;
    bit          clr;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    cordicIf.interrupt = intPulse;
    cordicIf.controlRegisterWriteEnable = ctrlWe;
    cordicIf.controlRegisterOutput = ctrlOut;
    checkOutput("req_ready_idle", {31'b0, req_ready}, 32'd1);

    expErr = (addr >= 3'd5);
    expRd  = '0;
    pulse  = 2'b00;
    clr    = 1'b0;
    if (!wr) begin
      case (addr)
        3'd0: expRd = cordicIf.xResult;
        3'd1: expRd = cordicIf.yResult;
        3'd2: expRd = cordicIf.zResult;
        3'd3: expRd = mImg;
        3'd4: expRd = {31'b0, mPend};
        default: expRd = '0;
      endcase
    end else begin
      case (addr)
        3'd0: mX = wdata;
        3'd1: mY = wdata;
        3'd2: mZ = wdata;
        3'd3: begin mImg[15:2] = wdata[15:2]; pulse = wdata[1:0]; end
        3'd4: clr = wdata[0];
        default: ;
      endcase
    end
    if (ctrlWe) begin
      mImg[31:16] = ctrlOut[31:16];
      if (!(wr && addr == 3'd3)) mImg[15:2] = ctrlOut[15:2];
    end
    if (intPulse) mPend = 1'b1;
    else if (clr) mPend = 1'b0;

    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cordicIf.interrupt = 1'b0;
    cordicIf.controlRegisterWriteEnable = 1'b0;
    lastRdata = resp_rdata;
    checkOutput("ctrl_in_pulse", cordicIf.controlRegisterInput, mImg | {30'b0, pulse});
    checkRegs();
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      resp_ready = (i == hold);
      checkOutput("resp_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("resp_rdata", resp_rdata, expRd);
      checkOutput("resp_err", {31'b0, resp_err}, {31'b0, expErr});
      checkOutput("req_ready_busy", {31'b0, req_ready}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("resp_done", {31'b0, resp_valid}, 32'd0);
    checkOutput("req_ready_back", {31'b0, req_ready}, 32'd1);
    checkOutput("ctrl_in_steady", cordicIf.controlRegisterInput, mImg);
  endtask

  task automatic pulseInterrupt();
    @(negedge clk);
    cordicIf.interrupt = 1'b1;
    @(negedge clk);
    cordicIf.interrupt = 1'b0;
    mPend = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    cordicIf.xResult = '0; cordicIf.yResult = '0; cordicIf.zResult = '0;
    cordicIf.controlRegisterOutput = '0;
    cordicIf.controlRegisterWriteEnable = 1'b0;
    cordicIf.interrupt = 1'b0;
    modelReset();
    lastRdata = '0;

    #3;
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
    checkOutput("rst_ctrl_in", cordicIf.controlRegisterInput, 32'd0);
    checkRegs();

    // Release just after an edge so the first request meets the first edge.
    @(posedge clk);
    #2 rst = 1'b1;

    // Operand write then result read.
    applyStimulus(1'b1, 3'd0, 32'h0000_1234, 0, 1'b0, 1'b0, '0);
    checkOutput("x_written", cordicIf.xInput, 32'h0000_1234);
    cordicIf.xResult = 32'hFFFF_0001;
    applyStimulus(1'b0, 3'd0, '0, 0, 1'b0, 1'b0, '0);
    checkOutput("x_read", lastRdata, 32'hFFFF_0001);

    // CTRL write with Start pulse, then read back without pulse bits.
    applyStimulus(1'b1, 3'd3, 32'h0000_0F05, 1, 1'b0, 1'b0, '0);
    checkOutput("ctrl_after_pulse", cordicIf.controlRegisterInput, 32'h0000_0F04);
    applyStimulus(1'b0, 3'd3, '0, 0, 1'b0, 1'b0, '0);
    checkOutput("ctrl_read", lastRdata, 32'h0000_0F04);

    // Host and controller write CTRL in the same cycle.
    applyStimulus(1'b1, 3'd3, 32'h0000_000C, 0, 1'b0, 1'b1, 32'h0015_0008);
    applyStimulus(1'b0, 3'd3, '0, 0, 1'b0, 1'b0, '0);
    checkOutput("ctrl_merge", lastRdata, 32'h0015_000C);

    // Interrupt set, clear, and clear colliding with a new edge.
    pulseInterrupt();
    checkOutput("irq_set", {31'b0, irq}, 32'd1);
    applyStimulus(1'b1, 3'd4, 32'd1, 0, 1'b0, 1'b0, '0);
    checkOutput("irq_cleared", {31'b0, irq}, 32'd0);
    applyStimulus(1'b1, 3'd4, 32'd1, 0, 1'b1, 1'b0, '0);
    checkOutput("irq_set_wins", {31'b0, irq}, 32'd1);
    applyStimulus(1'b0, 3'd4, '0, 0, 1'b0, 1'b0, '0);
    checkOutput("irqstat_read", lastRdata, 32'd1);

    // Unmapped read with a stalled response, and an unmapped write.
    applyStimulus(1'b0, 3'd6, '0, 3, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 3'd7, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, '0);

    // Reset asserted while a response is pending takes effect immediately.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("pre_rst_resp_valid", {31'b0, resp_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkOutput("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("mid_rst_irq", {31'b0, irq}, 32'd0);
    checkOutput("mid_rst_ctrl_in", cordicIf.controlRegisterInput, 32'd0);
    checkOutput("mid_rst_rdata", resp_rdata, 32'd0);
    checkRegs();
    @(posedge clk);
    #2 rst = 1'b1;

    // Randomized traffic, including core events in the accepting cycle.
    for (int n = 0; n < 150; n++) begin
      cordicIf.xResult = $urandom;
      cordicIf.yResult = $urandom;
      cordicIf.zResult = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                    int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
